tile_vram_port: RTL and testbench

- 68K-side access port for the tile layer: the stage directly downstream of the address decoder.
- Consumes the decoder's tile_ofs_cs, tile_attr_cs, tile_num_cs and scroll_cs strobes.
- Holds the tile offset pointer and the 8 scroll registers.
- Runs a request/acknowledge handshake to the tile VRAM, which is shared with the tile renderer, and generates DTACK for these accesses.

---
 rtl/toaplan1_pkg.sv | 26 ++
 rtl/tile_vram_port_scroll_regfile.sv | 34 +++
 rtl/tile_vram_port.sv | 132 +++++++++++++
 tb/tb_tile_vram_port.sv | 308 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/toaplan1_pkg.sv
// Shared types and constants for the tile layer CPU port.
package toaplan1_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_DONE = 2'd2
  } port_state_e;

  localparam int unsigned SCROLL_REGS = 8;

  localparam logic ATTR_WORD = 1'b0;
  localparam logic NUM_WORD  = 1'b1;

  // Replace the bytes of old_val selected by be = {upper, lower} with new_val.
  function automatic logic [15:0] byte_merge(input logic [15:0] old_val,
                                             input logic [15:0] new_val,
                                             input logic [1:0]  be);
    logic [15:0] r;
    r = old_val;
    if (be[1]) r[15:8] = new_val[15:8];
    if (be[0]) r[7:0]  = new_val[7:0];
    return r;
  endfunction

endpackage

// File: rtl/tile_vram_port_scroll_regfile.sv
// Eight 16-bit byte-writable scroll registers with an indexed read port.
module scroll_regfile
  import toaplan1_pkg::*;
(
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        we,
  input  logic [2:0]                  idx,
  input  logic [1:0]                  be,
  input  logic [15:0]                 wdata,
  output logic [15:0]                 rdata,
  output logic [16*SCROLL_REGS-1:0]   regs_flat
);

  logic [15:0] regs [SCROLL_REGS];

  // Register bank: cleared on reset, byte-merged write of the indexed entry.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < SCROLL_REGS; i++) regs[i] <= '0;
    end else if (we) begin
      regs[idx] <= byte_merge(regs[idx], wdata, be);
    end
  end

  assign rdata = regs[idx];

  // Flatten the bank so register n sits at bits [16n+15:16n].
  always_comb begin
    regs_flat = '0;
    for (int unsigned i = 0; i < SCROLL_REGS; i++) regs_flat[16*i +: 16] = regs[i];
  end

endmodule

// File: rtl/tile_vram_port.sv
// 68K access port for the tile layer: offset pointer, scroll registers and
// request/acknowledge access to the shared tile VRAM, with DTACK generation.
module tile_vram_port
  import toaplan1_pkg::*;
#(
  parameter int unsigned OFS_W    = 14,
  parameter bit          AUTO_INC = 1'b1
) (
  input  logic               clk_sys,
  input  logic               reset,
  input  logic [3:0]         cpu_a,
  input  logic [15:0]        cpu_din,
  input  logic               cpu_rw,
  input  logic               cpu_uds_n,
  input  logic               cpu_lds_n,
  input  logic               cpu_as_n,
  input  logic               tile_ofs_cs,
  input  logic               tile_attr_cs,
  input  logic               tile_num_cs,
  input  logic               scroll_cs,
  output logic [15:0]        cpu_dout,
  output logic               cpu_dtack_n,
  output logic [OFS_W:0]     vram_addr,
  output logic [15:0]        vram_din,
  output logic [1:0]         vram_we,
  output logic               vram_req,
  input  logic               vram_ack,
  input  logic [15:0]        vram_dout,
  output logic [127:0]       scroll_regs
);

  port_state_e      state, state_nx;
  logic [OFS_W-1:0] offset;
  logic             acc_num;
  logic             acc_read;
  logic [15:0]      ofs_ext;
  logic [15:0]      ofs_wr;
  logic [15:0]      scroll_rdata;
  logic [1:0]       be;
  logic             start;
  logic             sel_ofs, sel_attr, sel_num, sel_scroll;
  logic             scroll_we;
  logic             unused_ok;

  assign be        = {~cpu_uds_n, ~cpu_lds_n};
  assign unused_ok = ^{cpu_a[0], ofs_wr};

  // Select decode with fixed priority ofs > attr > num > scroll, only in IDLE.
  always_comb begin
    start      = (state == ST_IDLE) && !cpu_as_n;
    sel_ofs    = start && tile_ofs_cs;
    sel_attr   = start && !tile_ofs_cs && tile_attr_cs;
    sel_num    = start && !tile_ofs_cs && !tile_attr_cs && tile_num_cs;
    sel_scroll = start && !tile_ofs_cs && !tile_attr_cs && !tile_num_cs && scroll_cs;
    scroll_we  = sel_scroll && !cpu_rw;
  end

  // Offset widened to bus width for reads and byte-merged writes.
  always_comb begin
    ofs_ext              = '0;
    ofs_ext[OFS_W-1:0]   = offset;
    ofs_wr               = byte_merge(ofs_ext, cpu_din, be);
  end

  scroll_regfile u_scroll (
    .clk       (clk_sys),
    .rst       (reset),
    .we        (scroll_we),
    .idx       (cpu_a[3:1]),
    .be        (be),
    .wdata     (cpu_din),
    .rdata     (scroll_rdata),
    .regs_flat (scroll_regs)
  );

  // FSM state register.
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nx;
  end

  // Next-state logic; DONE waits for AS to rise so one bus cycle executes once.
  always_comb begin
    state_nx = state;
    unique case (state)
      ST_IDLE: begin
        if (sel_ofs || sel_scroll)    state_nx = ST_DONE;
        else if (sel_attr || sel_num) state_nx = ST_REQ;
      end
      ST_REQ:  if (vram_ack) state_nx = ST_DONE;
      ST_DONE: if (cpu_as_n) state_nx = ST_IDLE;
      default: state_nx = ST_IDLE;
    endcase
  end

  assign cpu_dtack_n = (state != ST_DONE);

  // Datapath: register accesses, VRAM request latching and completion.
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      offset    <= '0;
      cpu_dout  <= '0;
      vram_addr <= '0;
      vram_din  <= '0;
      vram_we   <= '0;
      vram_req  <= 1'b0;
      acc_num   <= 1'b0;
      acc_read  <= 1'b0;
    end else begin
      if (sel_ofs) begin
        if (cpu_rw) cpu_dout <= ofs_ext;
        else        offset   <= ofs_wr[OFS_W-1:0];
      end
      if (sel_scroll && cpu_rw) cpu_dout <= scroll_rdata;
      if (sel_attr || sel_num) begin
        vram_addr <= {offset, (sel_num ? NUM_WORD : ATTR_WORD)};
        vram_din  <= cpu_din;
        vram_we   <= cpu_rw ? 2'b00 : be;
        vram_req  <= 1'b1;
        acc_num   <= sel_num;
        acc_read  <= cpu_rw;
      end
      if (state == ST_REQ && vram_ack) begin
        vram_req <= 1'b0;
        vram_we  <= '0;
        if (acc_read) cpu_dout <= vram_dout;
        if (acc_num && AUTO_INC) offset <= offset + OFS_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_tile_vram_port.sv
// Directed bench for tile_vram_port with queue-based response checking.
module tb_tile_vram_port;

  localparam int OFS_W = 14;
  localparam logic [3:0] S_OFS  = 4'b0001;
  localparam logic [3:0] S_ATTR = 4'b0010;
  localparam logic [3:0] S_NUM  = 4'b0100;
  localparam logic [3:0] S_SCR  = 4'b1000;

  logic           clk_sys = 1'b0;
  logic           reset = 1'b1;
  logic [3:0]     cpu_a = '0;
  logic [15:0]    cpu_din = '0;
  logic           cpu_rw = 1'b1;
  logic           cpu_uds_n = 1'b1;
  logic           cpu_lds_n = 1'b1;
  logic           cpu_as_n = 1'b1;
  logic           tile_ofs_cs = 1'b0;
  logic           tile_attr_cs = 1'b0;
  logic           tile_num_cs = 1'b0;
  logic           scroll_cs = 1'b0;
  logic [15:0]    cpu_dout;
  logic           cpu_dtack_n;
  logic [OFS_W:0] vram_addr;
  logic [15:0]    vram_din;
  logic [1:0]     vram_we;
  logic           vram_req;
  logic           vram_ack = 1'b0;
  logic [15:0]    vram_dout = '0;
  logic [127:0]   scroll_regs;

  always #5 clk_sys = ~clk_sys;

  tile_vram_port #(.OFS_W(OFS_W), .AUTO_INC(1'b1)) dut (
    .clk_sys      (clk_sys),
    .reset        (reset),
    .cpu_a        (cpu_a),
    .cpu_din      (cpu_din),
    .cpu_rw       (cpu_rw),
    .cpu_uds_n    (cpu_uds_n),
    .cpu_lds_n    (cpu_lds_n),
    .cpu_as_n     (cpu_as_n),
    .tile_ofs_cs  (tile_ofs_cs),
    .tile_attr_cs (tile_attr_cs),
    .tile_num_cs  (tile_num_cs),
    .scroll_cs    (scroll_cs),
    .cpu_dout     (cpu_dout),
    .cpu_dtack_n  (cpu_dtack_n),
    .vram_addr    (vram_addr),
    .vram_din     (vram_din),
    .vram_we      (vram_we),
    .vram_req     (vram_req),
    .vram_ack     (vram_ack),
    .vram_dout    (vram_dout),
    .scroll_regs  (scroll_regs)
  );

  int total = 0;
  int bad = 0;

  // Expected bus responses (one per DTACK) and VRAM requests (one per req rise).
  bit             resp_chk_q[$];
  logic [15:0]    resp_dout_q[$];
  logic [OFS_W:0] vq_addr[$];
  logic [1:0]     vq_we[$];
  logic [15:0]    vq_din[$];

  logic [OFS_W:0] cur_addr;
  logic [1:0]     cur_we;
  logic [15:0]    cur_din;
  bit             cur_valid = 1'b0;
  logic           dtack_prev = 1'b1;
  logic           req_prev = 1'b0;
  bit             mon_c;
  logic [15:0]    mon_d;

  logic [15:0]    exp_scr [8];

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  function automatic logic [127:0] scr_flat();
    logic [127:0] r;
    for (int i = 0; i < 8; i++) r[16*i +: 16] = exp_scr[i];
    return r;
  endfunction

  // Monitor: pops expectations when the DUT presents DTACK or a new VRAM request.
  always @(negedge clk_sys) begin
    if (!reset) begin
      if (!cpu_dtack_n && dtack_prev) begin
        if (resp_chk_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL dtack_unexpected: got dtack_n=0 want 1");
        end else begin
          mon_c = resp_chk_q.pop_front();
          mon_d = resp_dout_q.pop_front();
          if (mon_c) chk("rd_dout", 128'(cpu_dout), 128'(mon_d));
        end
      end
      if (vram_req && !req_prev) begin
        if (vq_addr.size() == 0) begin
          total++;
          bad++;
          $display("FAIL vram_req_unexpected: got req=1 want 0");
        end else begin
          cur_addr  = vq_addr.pop_front();
          cur_we    = vq_we.pop_front();
          cur_din   = vq_din.pop_front();
          cur_valid = 1'b1;
        end
      end
      if (vram_req && cur_valid) begin
        chk("vram_addr", 128'(vram_addr), 128'(cur_addr));
        chk("vram_we",   128'(vram_we),   128'(cur_we));
        chk("vram_din",  128'(vram_din),  128'(cur_din));
      end
    end
    if (!vram_req) cur_valid = 1'b0;
    dtack_prev = cpu_dtack_n;
    req_prev   = vram_req;
  end

  // One 68K bus cycle; ack is pulsed after vram_req has been seen ack_delay clocks.
  task automatic bus(input logic [3:0] sel, input logic rw, input logic [3:0] a,
                     input logic [15:0] d, input logic [1:0] strb_n,
                     input int ack_delay, input logic [15:0] rd,
                     output int lat, output int reqc);
    @(posedge clk_sys); #1;
    {scroll_cs, tile_num_cs, tile_attr_cs, tile_ofs_cs} = sel;
    cpu_rw = rw;
    cpu_a = a;
    cpu_din = d;
    {cpu_uds_n, cpu_lds_n} = strb_n;
    cpu_as_n = 1'b0;
    lat = 0;
    reqc = 0;
    while (cpu_dtack_n && lat < 64) begin
      @(posedge clk_sys); #1;
      lat++;
      vram_ack = 1'b0;
      if (vram_req) begin
        reqc++;
        if (reqc == ack_delay) begin
          vram_ack = 1'b1;
          vram_dout = rd;
        end
      end
    end
    vram_ack = 1'b0;
    if (cpu_dtack_n) begin
      total++;
      bad++;
      $display("FAIL dtack_timeout: got dtack_n=1 want 0 after %0d clocks", lat);
    end else begin
      repeat (2) @(posedge clk_sys);
      #1;
      chk("dtack_hold", 128'(cpu_dtack_n), 128'(0));
    end
    cpu_as_n = 1'b1;
    {scroll_cs, tile_num_cs, tile_attr_cs, tile_ofs_cs} = 4'b0000;
    cpu_rw = 1'b1;
    {cpu_uds_n, cpu_lds_n} = 2'b11;
    @(posedge clk_sys); #1;
    chk("dtack_release", 128'(cpu_dtack_n), 128'(1));
  endtask

  task automatic reg_wr(input logic [3:0] sel, input logic [3:0] a,
                        input logic [15:0] d, input logic [1:0] strb_n);
    int lat, reqc;
    resp_chk_q.push_back(1'b0);
    resp_dout_q.push_back(16'h0000);
    bus(sel, 1'b0, a, d, strb_n, 0, 16'h0000, lat, reqc);
    chk("reg_wr_latency", 128'(lat), 128'(1));
  endtask

  task automatic reg_rd(input logic [3:0] sel, input logic [3:0] a, input logic [15:0] exp);
    int lat, reqc;
    resp_chk_q.push_back(1'b1);
    resp_dout_q.push_back(exp);
    bus(sel, 1'b1, a, 16'h0000, 2'b00, 0, 16'h0000, lat, reqc);
    chk("reg_rd_latency", 128'(lat), 128'(1));
  endtask

  task automatic vram_acc(input logic [3:0] sel, input logic rw, input logic [15:0] d,
                          input logic [1:0] strb_n, input int delay, input logic [15:0] rd,
                          input logic [OFS_W:0] eaddr, input logic [1:0] ewe);
    int lat, reqc;
    vq_addr.push_back(eaddr);
    vq_we.push_back(ewe);
    vq_din.push_back(d);
    resp_chk_q.push_back(rw);
    resp_dout_q.push_back(rd);
    bus(sel, rw, 4'h0, d, strb_n, delay, rd, lat, reqc);
    chk("vram_latency", 128'(lat), 128'(delay + 1));
    chk("vram_req_cycles", 128'(reqc), 128'(delay));
  endtask

  initial begin
    for (int i = 0; i < 8; i++) exp_scr[i] = 16'h0000;

    // Reset state.
    repeat (3) @(posedge clk_sys);
    #1;
    chk("rst_dtack", 128'(cpu_dtack_n), 128'(1));
    chk("rst_req",   128'(vram_req),    128'(0));
    chk("rst_we",    128'(vram_we),     128'(0));
    chk("rst_dout",  128'(cpu_dout),    128'(0));
    chk("rst_scroll", scroll_regs, 128'(0));
    @(negedge clk_sys);
    reset = 1'b0;

    // Scroll contents are cleared by reset.
    reg_wr(S_SCR, 4'b0100, 16'hABCD, 2'b00);
    exp_scr[2] = 16'hABCD;
    chk("scroll_before_rst", scroll_regs, scr_flat());
    @(negedge clk_sys);
    reset = 1'b1;
    #1;
    exp_scr[2] = 16'h0000;
    chk("scroll_after_rst", scroll_regs, scr_flat());
    chk("rst2_dtack", 128'(cpu_dtack_n), 128'(1));
    chk("rst2_req",   128'(vram_req),    128'(0));
    @(negedge clk_sys);
    reset = 1'b0;

    // Offset 0x0123, attr write acked after 3 request clocks.
    reg_wr(S_OFS, 4'h0, 16'h0123, 2'b00);
    vram_acc(S_ATTR, 1'b0, 16'hA5A5, 2'b00, 3, 16'h0000, 15'h0246, 2'b11);
    reg_rd(S_OFS, 4'h0, 16'h0123);

    // Num write at the top offset wraps the pointer to zero.
    reg_wr(S_OFS, 4'h0, 16'h3FFF, 2'b00);
    vram_acc(S_NUM, 1'b0, 16'h1234, 2'b00, 1, 16'h0000, 15'h7FFF, 2'b11);
    reg_rd(S_OFS, 4'h0, 16'h0000);

    // Bits above the pointer width are dropped; upper-byte-only write.
    reg_wr(S_OFS, 4'h0, 16'hFFFF, 2'b00);
    reg_rd(S_OFS, 4'h0, 16'h3FFF);
    reg_wr(S_OFS, 4'h0, 16'h1200, 2'b01);
    reg_rd(S_OFS, 4'h0, 16'h12FF);

    // Attr read: data from VRAM, no write enables, no increment.
    vram_acc(S_ATTR, 1'b1, 16'h0000, 2'b00, 2, 16'hBEEF, 15'h25FE, 2'b00);
    reg_rd(S_OFS, 4'h0, 16'h12FF);

    // Num read: data from VRAM and the pointer advances.
    vram_acc(S_NUM, 1'b1, 16'h0000, 2'b00, 1, 16'h5A5A, 15'h25FF, 2'b00);
    reg_rd(S_OFS, 4'h0, 16'h1300);

    // Scroll bank: full writes then a lower-byte-only update of reg 5.
    reg_wr(S_SCR, 4'b1010, 16'h1234, 2'b00);
    exp_scr[5] = 16'h1234;
    reg_wr(S_SCR, 4'b0000, 16'h1111, 2'b00);
    exp_scr[0] = 16'h1111;
    reg_wr(S_SCR, 4'b1010, 16'h00CD, 2'b10);
    exp_scr[5] = 16'h12CD;
    chk("scroll_lower_byte", scroll_regs, scr_flat());
    reg_rd(S_SCR, 4'b1010, 16'h12CD);

    // Priority: offset select wins over scroll, attr wins over num.
    reg_wr(S_OFS | S_SCR, 4'b0000, 16'h0042, 2'b00);
    chk("prio_scroll_untouched", scroll_regs, scr_flat());
    reg_rd(S_OFS, 4'h0, 16'h0042);
    vram_acc(S_ATTR | S_NUM, 1'b0, 16'h9999, 2'b00, 1, 16'h0000, 15'h0084, 2'b11);
    reg_rd(S_OFS, 4'h0, 16'h0042);

    // Reset while a VRAM request is pending.
    vq_addr.push_back(15'h0084);
    vq_we.push_back(2'b11);
    vq_din.push_back(16'h7777);
    @(posedge clk_sys); #1;
    tile_attr_cs = 1'b1;
    cpu_rw = 1'b0;
    cpu_din = 16'h7777;
    {cpu_uds_n, cpu_lds_n} = 2'b00;
    cpu_as_n = 1'b0;
    repeat (2) @(posedge clk_sys);
    #1;
    chk("midreq_req_high", 128'(vram_req), 128'(1));
    reset = 1'b1;
    #1;
    chk("midreq_req_drop", 128'(vram_req),    128'(0));
    chk("midreq_we_drop",  128'(vram_we),     128'(0));
    chk("midreq_dtack",    128'(cpu_dtack_n), 128'(1));
    tile_attr_cs = 1'b0;
    cpu_rw = 1'b1;
    {cpu_uds_n, cpu_lds_n} = 2'b11;
    cpu_as_n = 1'b1;
    @(negedge clk_sys);
    reset = 1'b0;
    for (int i = 0; i < 8; i++) exp_scr[i] = 16'h0000;
    chk("midreq_scroll", scroll_regs, scr_flat());
    reg_rd(S_OFS, 4'h0, 16'h0000);

    repeat (3) @(posedge clk_sys);
    chk("queues_empty", 128'(resp_chk_q.size() + vq_addr.size()), 128'(0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
